// File: rtl/ah_cam_wr_credit_tx_if.sv
// ah_cam_wr_credit_tx_if: upstream request, CAM write and credit/status signals
interface ah_cam_wr_credit_tx_if #(parameter int DWIDTH = 64);
  logic              in_valid;
  logic              in_ready;
  logic [DWIDTH-1:0] in_data;
  logic              wvalid;
  logic [DWIDTH-1:0] wdata;
  logic              wcredit;
  logic [5:0]        credit_cnt;
  logic [2:0]        fifo_level;
  logic              credit_err;
  modport master (
    output in_valid, in_data, wcredit,
    input  in_ready, wvalid, wdata, credit_cnt, fifo_level, credit_err
  );
  modport slave (
    input  in_valid, in_data, wcredit,
    output in_ready, wvalid, wdata, credit_cnt, fifo_level, credit_err
  );
endinterface

// File: rtl/ah_cam_wr_credit_tx.sv
// ah_cam_wr_credit_tx: buffered CAM writer gated by a downstream credit counter
module ah_cam_wr_credit_tx #(
  parameter int DWIDTH  = 64,
  parameter int CREDITS = 50,
  parameter int FDEPTH  = 4
) (
  input logic clk,
  input logic rst,
  ah_cam_wr_credit_tx_if.slave bus
);
  localparam int AW = FDEPTH > 1 ? $clog2(FDEPTH) : 1;
  logic [DWIDTH-1:0] mem [FDEPTH];
  logic [AW-1:0]     rd_ptr, wr_ptr, rd_nxt, wr_nxt;
  logic [5:0]        credit_cnt, credit_nxt;
  logic [2:0]        fifo_level, level_nxt;
  logic              credit_err, err_set, wvalid, push, send;
  logic [DWIDTH-1:0] wdata;
  assign bus.in_ready   = fifo_level != 3'(FDEPTH);
  assign bus.wvalid     = wvalid;
  assign bus.wdata      = wdata;
  assign bus.credit_cnt = credit_cnt;
  assign bus.fifo_level = fifo_level;
  assign bus.credit_err = credit_err;
  assign push = bus.in_valid && bus.in_ready;
  // a credit returned this cycle only becomes usable next cycle, so send looks at the registered count
  assign send = fifo_level != '0 && credit_cnt != '0;
  // next-state arithmetic for credits, level and wrapping pointers
  always_comb begin
    credit_nxt = (send && !bus.wcredit) ? credit_cnt - 6'd1 :
                 (bus.wcredit && !send && credit_cnt != 6'(CREDITS)) ? credit_cnt + 6'd1 : credit_cnt;
    err_set    = bus.wcredit && !send && credit_cnt == 6'(CREDITS);
    level_nxt  = (push && !send) ? fifo_level + 3'd1 : (send && !push) ? fifo_level - 3'd1 : fifo_level;
    rd_nxt     = rd_ptr == AW'(FDEPTH - 1) ? '0 : rd_ptr + 1'b1;
    wr_nxt     = wr_ptr == AW'(FDEPTH - 1) ? '0 : wr_ptr + 1'b1;
  end
  // buffer storage needs no reset; pointers and level define what is valid
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.in_data;
  end
  // control state and the registered CAM write strobe/payload
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credit_cnt <= 6'(CREDITS);
      fifo_level <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      wvalid     <= 1'b0;
      wdata      <= '0;
      credit_err <= 1'b0;
    end else begin
      credit_cnt <= credit_nxt;
      fifo_level <= level_nxt;
      credit_err <= credit_err | err_set;
      wvalid     <= send;
      if (send) wdata <= mem[rd_ptr];
      if (send) rd_ptr <= rd_nxt;
      if (push) wr_ptr <= wr_nxt;
    end
  end
endmodule

// File: tb/tb_ah_cam_wr_credit_tx.sv
// tb_ah_cam_wr_credit_tx: randomized scenario tests against a queue-based model
module tb_ah_cam_wr_credit_tx;
  localparam int DW = 64, CR = 50, FD = 4;
  logic clk = 0, rst = 1;
  int n_checks = 0, n_fail = 0;
  logic [DW-1:0] q[$];
  int m_cred;
  bit m_err, m_wvalid;
  logic [DW-1:0] m_wdata;
  ah_cam_wr_credit_tx_if #(.DWIDTH(DW)) bus ();
  ah_cam_wr_credit_tx #(.DWIDTH(DW), .CREDITS(CR), .FDEPTH(FD)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rnd();
    return {$urandom, $urandom};
  endfunction

  task automatic model_reset();
    q.delete();
    m_cred = CR;
    m_err = 0;
    m_wvalid = 0;
    m_wdata = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    bus.in_valid = 0;
    bus.wcredit = 0;
    model_reset();
    @(negedge clk);
    rst = 0;
  endtask

  // one clock: drive inputs, advance the model, sample 1 ns after the edge
  task automatic step(input bit v, input logic [DW-1:0] d, input bit c);
    bit push, send;
    @(negedge clk);
    bus.in_valid = v;
    bus.in_data = d;
    bus.wcredit = c;
    push = v && q.size() != FD;
    send = q.size() != 0 && m_cred != 0;
    m_wvalid = send;
    if (send) m_wdata = q.pop_front();
    if (push) q.push_back(d);
    if (send && !c) m_cred--;
    else if (c && !send) begin
      if (m_cred == CR) m_err = 1;
      else m_cred++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    #2 rst = 1;
    bus.in_valid = 1;
    bus.wcredit = 1;
    #1;
    n_checks += 5;
    if (bus.credit_cnt !== 6'(CR)) begin n_fail++; $display("FAIL reset_credit got %0d exp %0d", bus.credit_cnt, CR); end
    if (bus.fifo_level !== 3'd0) begin n_fail++; $display("FAIL reset_level got %0d exp 0", bus.fifo_level); end
    if (bus.wvalid !== 1'b0 || bus.wdata !== '0) begin n_fail++; $display("FAIL reset_wr got %b/%h exp 0/0", bus.wvalid, bus.wdata); end
    if (bus.credit_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b exp 0", bus.credit_err); end
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b exp 1", bus.in_ready); end
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.fifo_level !== 3'd0 || bus.credit_cnt !== 6'(CR)) begin n_fail++; $display("FAIL reset_ignore level %0d credit %0d", bus.fifo_level, bus.credit_cnt); end
    do_reset();
  endtask

  task automatic test_single_write();
    do_reset();
    step(1, 64'h1234, 0);
    n_checks += 2;
    if (bus.wvalid !== 1'b0) begin n_fail++; $display("FAIL single_early wvalid got %b exp 0", bus.wvalid); end
    if (bus.fifo_level !== 3'd1) begin n_fail++; $display("FAIL single_level1 got %0d exp 1", bus.fifo_level); end
    step(0, 0, 0);
    n_checks += 3;
    if (bus.wvalid !== 1'b1 || bus.wdata !== 64'h1234) begin n_fail++; $display("FAIL single_write got %b/%h exp 1/1234", bus.wvalid, bus.wdata); end
    if (bus.credit_cnt !== 6'd49) begin n_fail++; $display("FAIL single_credit got %0d exp 49", bus.credit_cnt); end
    if (bus.fifo_level !== 3'd0) begin n_fail++; $display("FAIL single_level0 got %0d exp 0", bus.fifo_level); end
    step(0, 0, 0);
    n_checks++;
    if (bus.wvalid !== 1'b0 || bus.wdata !== 64'h1234) begin n_fail++; $display("FAIL single_hold got %b/%h exp 0/1234", bus.wvalid, bus.wdata); end
  endtask

  task automatic test_exhaustion();
    int sent = 0;
    do_reset();
    for (int i = 0; i < 56; i++) begin
      step(i < 54, rnd(), 0);
      n_checks++;
      if (bus.wvalid !== m_wvalid || (m_wvalid && bus.wdata !== m_wdata)) begin
        n_fail++;
        $display("FAIL exhaust_order cyc %0d got %b/%h exp %b/%h", i, bus.wvalid, bus.wdata, m_wvalid, m_wdata);
      end
      if (bus.wvalid === 1'b1) sent++;
    end
    n_checks += 4;
    if (sent != 50) begin n_fail++; $display("FAIL exhaust_count got %0d exp 50", sent); end
    if (bus.credit_cnt !== 6'd0) begin n_fail++; $display("FAIL exhaust_credit got %0d exp 0", bus.credit_cnt); end
    if (bus.fifo_level !== 3'd4) begin n_fail++; $display("FAIL exhaust_level got %0d exp 4", bus.fifo_level); end
    if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL exhaust_ready got %b exp 0", bus.in_ready); end
  endtask

  task automatic test_credit_return();
    step(0, 0, 1);
    n_checks += 2;
    if (bus.credit_cnt !== 6'd1 || bus.wvalid !== 1'b0) begin n_fail++; $display("FAIL ret_credit got %0d/%b exp 1/0", bus.credit_cnt, bus.wvalid); end
    if (bus.fifo_level !== 3'd4) begin n_fail++; $display("FAIL ret_level4 got %0d exp 4", bus.fifo_level); end
    step(0, 0, 0);
    n_checks += 3;
    if (bus.wvalid !== 1'b1 || bus.wdata !== m_wdata) begin n_fail++; $display("FAIL ret_send got %b/%h exp 1/%h", bus.wvalid, bus.wdata, m_wdata); end
    if (bus.credit_cnt !== 6'd0) begin n_fail++; $display("FAIL ret_credit0 got %0d exp 0", bus.credit_cnt); end
    if (bus.fifo_level !== 3'd3) begin n_fail++; $display("FAIL ret_level3 got %0d exp 3", bus.fifo_level); end
  endtask

  task automatic test_simultaneous();
    logic [DW-1:0] d = rnd();
    do_reset();
    for (int i = 0; i < 40; i++) step(1, rnd(), 0);
    repeat (2) step(0, 0, 0);
    step(1, d, 0);
    n_checks++;
    if (bus.credit_cnt !== 6'd10) begin n_fail++; $display("FAIL simul_pre got %0d exp 10", bus.credit_cnt); end
    step(0, 0, 1);
    n_checks += 2;
    if (bus.credit_cnt !== 6'd10) begin n_fail++; $display("FAIL simul_credit got %0d exp 10", bus.credit_cnt); end
    if (bus.wvalid !== 1'b1 || bus.wdata !== d) begin n_fail++; $display("FAIL simul_write got %b/%h exp 1/%h", bus.wvalid, bus.wdata, d); end
  endtask

  task automatic test_overflow();
    do_reset();
    step(0, 0, 1);
    n_checks++;
    if (bus.credit_cnt !== 6'(CR) || bus.credit_err !== 1'b1) begin n_fail++; $display("FAIL ovf_set got %0d/%b exp 50/1", bus.credit_cnt, bus.credit_err); end
    for (int i = 0; i < 5; i++) step(1, rnd(), 0);
    n_checks++;
    if (bus.credit_err !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %b exp 1", bus.credit_err); end
    do_reset();
    #1;
    n_checks++;
    if (bus.credit_err !== 1'b0) begin n_fail++; $display("FAIL ovf_clear got %b exp 0", bus.credit_err); end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    for (int i = 0; i < 53; i++) step(1, rnd(), 0);
    for (int i = 0; i < 20; i++) step(0, 0, 1);
    n_checks++;
    if (bus.fifo_level !== 3'(q.size()) || bus.credit_cnt !== 6'(m_cred)) begin
      n_fail++;
      $display("FAIL mid_pre got %0d/%0d exp %0d/%0d", bus.fifo_level, bus.credit_cnt, q.size(), m_cred);
    end
    #2 rst = 1;
    #1;
    n_checks += 2;
    if (bus.fifo_level !== 3'd0 || bus.credit_cnt !== 6'(CR)) begin n_fail++; $display("FAIL mid_state got %0d/%0d exp 0/50", bus.fifo_level, bus.credit_cnt); end
    if (bus.wvalid !== 1'b0 || bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_outs got %b/%b exp 0/1", bus.wvalid, bus.in_ready); end
    model_reset();
    @(negedge clk);
    rst = 0;
    step(0, 0, 0);
    n_checks++;
    if (bus.wvalid !== 1'b0) begin n_fail++; $display("FAIL mid_after got %b exp 0", bus.wvalid); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, rnd(), $urandom_range(0, 4) == 0);
      n_checks++;
      if (bus.wvalid !== m_wvalid || (m_wvalid && bus.wdata !== m_wdata) ||
          bus.credit_cnt !== 6'(m_cred) || bus.fifo_level !== 3'(q.size()) ||
          bus.in_ready !== (q.size() != FD) || bus.credit_err !== m_err) begin
        n_fail++;
        $display("FAIL random cyc %0d got v%b d%h c%0d l%0d r%b e%b exp v%b d%h c%0d l%0d e%b", i,
                 bus.wvalid, bus.wdata, bus.credit_cnt, bus.fifo_level, bus.in_ready, bus.credit_err,
                 m_wvalid, m_wdata, m_cred, q.size(), m_err);
      end
    end
  endtask

  initial begin
    bus.in_valid = 0;
    bus.in_data = '0;
    bus.wcredit = 0;
    model_reset();
    test_reset();
    test_single_write();
    test_exhaustion();
    test_credit_return();
    test_simultaneous();
    test_overflow();
    test_reset_midstream();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
